// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - ALU-side, data-cache and writeback handshake bundle for the memory stage
interface mem_access_stage_if #(
    parameter int WORDSZ = 64,
    parameter int REGSZ  = 5,
    parameter int STRBSZ = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_is_load;
    logic              in_is_store;
    logic [2:0]        in_funct3;
    logic [WORDSZ-1:0] in_addr;
    logic [WORDSZ-1:0] in_store_data;
    logic [REGSZ-1:0]  in_rd;

    logic              dc_req;
    logic              dc_we;
    logic [WORDSZ-1:0] dc_addr;
    logic [WORDSZ-1:0] dc_wdata;
    logic [STRBSZ-1:0] dc_wstrb;
    logic              dc_ack;
    logic [WORDSZ-1:0] dc_rdata;

    logic              out_valid;
    logic              out_ready;
    logic [WORDSZ-1:0] out_data;
    logic [REGSZ-1:0]  out_rd;
    logic              out_wr_en;
    logic              out_ld_or_alu;
    logic              out_misaligned;

    modport master (
        input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_store_data, in_rd,
        output in_ready,
        output dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb,
        input  dc_ack, dc_rdata,
        output out_valid, out_data, out_rd, out_wr_en, out_ld_or_alu, out_misaligned,
        input  out_ready
    );

    modport slave (
        output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_store_data, in_rd,
        input  in_ready,
        input  dc_req, dc_we, dc_addr, dc_wdata, dc_wstrb,
        output dc_ack, dc_rdata,
        input  out_valid, out_data, out_rd, out_wr_en, out_ld_or_alu, out_misaligned,
        output out_ready
    );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store memory stage: cache request/ack, lane formatting, writeback handoff
module mem_access_stage #(
    parameter int WORDSZ = 64,
    parameter int REGSZ  = 5,
    parameter int STRBSZ = 8
) (
    input  logic clk,
    input  logic reset,
    mem_access_stage_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

  state_t              state_q, state_d;
  logic [WORDSZ-1:0]   addr_q, addr_d;
  logic [2:0]          f3_q, f3_d;
  logic                ld_q, ld_d;
  logic                we_q, we_d;
  logic [WORDSZ-1:0]   wdata_q, wdata_d;
  logic [STRBSZ-1:0]   wstrb_q, wstrb_d;
  logic [REGSZ-1:0]    rd_q, rd_d;
  logic                mis_q, mis_d;
  logic                wr_en_q, wr_en_d;
  logic [WORDSZ-1:0]   data_q, data_d;

  logic [2:0]          a_in;
  logic                ld_in, st_in, mem_in, aligned_in, illegal_in, mis_in;
  logic [STRBSZ-1:0]   strb_base;

  function automatic logic [WORDSZ-1:0] fmt_load(input logic [WORDSZ-1:0] rdata,
                                                 input logic [2:0] a,
                                                 input logic [2:0] f3);
    logic [WORDSZ-1:0] lane;
    lane = rdata >> {a, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{(WORDSZ-8){lane[7]}}, lane[7:0]};
      3'b001:  fmt_load = {{(WORDSZ-16){lane[15]}}, lane[15:0]};
      3'b010:  fmt_load = {{(WORDSZ-32){lane[31]}}, lane[31:0]};
      3'b100:  fmt_load = {{(WORDSZ-8){1'b0}}, lane[7:0]};
      3'b101:  fmt_load = {{(WORDSZ-16){1'b0}}, lane[15:0]};
      3'b110:  fmt_load = {{(WORDSZ-32){1'b0}}, lane[31:0]};
      default: fmt_load = lane;
    endcase
  endfunction

  // Load wins when both op flags are set, so a store is only a store alone.
  assign a_in   = bus.in_addr[2:0];
  assign ld_in  = bus.in_is_load;
  assign st_in  = bus.in_is_store & ~bus.in_is_load;
  assign mem_in = ld_in | st_in;

  always_comb begin
    aligned_in = 1'b1;
    strb_base  = '0;
    case (bus.in_funct3[1:0])
      2'b00: begin aligned_in = 1'b1;             strb_base = STRBSZ'(8'h01); end
      2'b01: begin aligned_in = (a_in[0] == 1'b0);  strb_base = STRBSZ'(8'h03); end
      2'b10: begin aligned_in = (a_in[1:0] == 2'b00); strb_base = STRBSZ'(8'h0F); end
      default: begin aligned_in = (a_in == 3'b000); strb_base = STRBSZ'(8'hFF); end
    endcase
  end

  assign illegal_in = ld_in ? (bus.in_funct3 == 3'b111) : (st_in & bus.in_funct3[2]);
  assign mis_in     = mem_in & (illegal_in | ~aligned_in);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    ld_d    = ld_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rd_d    = rd_q;
    mis_d   = mis_q;
    wr_en_d = wr_en_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          addr_d  = bus.in_addr;
          f3_d    = bus.in_funct3;
          rd_d    = bus.in_rd;
          mis_d   = mis_in;
          ld_d    = ld_in & ~mis_in;
          we_d    = st_in & ~mis_in;
          wdata_d = (st_in & ~mis_in) ? (bus.in_store_data << {a_in, 3'b000}) : '0;
          wstrb_d = (st_in & ~mis_in) ? (strb_base << a_in) : '0;
          wr_en_d = ~st_in & ~mis_in & (bus.in_rd != '0);
          data_d  = bus.in_addr;
          state_d = (mem_in & ~mis_in) ? REQ : OUT;
        end
      end
      REQ: begin
        if (bus.dc_ack) begin
          if (ld_q) data_d = fmt_load(bus.dc_rdata, addr_q[2:0], f3_q);
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      ld_q    <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      wr_en_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      ld_q    <= ld_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
    end
  end

  // in_ready is qualified by reset so it stays low while reset is held.
  assign bus.in_ready       = (state_q == IDLE) & reset;
  assign bus.dc_req         = (state_q == REQ);
  assign bus.dc_we          = we_q;
  assign bus.dc_addr        = {addr_q[WORDSZ-1:3], 3'b000};
  assign bus.dc_wdata       = wdata_q;
  assign bus.dc_wstrb       = wstrb_q;
  assign bus.out_valid      = (state_q == OUT);
  assign bus.out_data       = data_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_wr_en      = wr_en_q;
  assign bus.out_ld_or_alu  = ld_q;
  assign bus.out_misaligned = mis_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  mem_access_stage_if #(.WORDSZ(64), .REGSZ(5), .STRBSZ(8)) bus ();

  mem_access_stage #(.WORDSZ(64), .REGSZ(5), .STRBSZ(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one transaction for a single cycle; returns at the negedge after acceptance.
  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] sdata, input logic [4:0] rd);
    bus.in_valid      = 1'b1;
    bus.in_is_load    = ld;
    bus.in_is_store   = st;
    bus.in_funct3     = f3;
    bus.in_addr       = addr;
    bus.in_store_data = sdata;
    bus.in_rd         = rd;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic ack(input logic [63:0] rdata);
    bus.dc_ack   = 1'b1;
    bus.dc_rdata = rdata;
    @(negedge clk);
    bus.dc_ack   = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.in_valid = 1'b0; bus.in_is_load = 1'b0; bus.in_is_store = 1'b0;
    bus.in_funct3 = 3'b000; bus.in_addr = '0; bus.in_store_data = '0; bus.in_rd = '0;
    bus.dc_ack = 1'b0; bus.dc_rdata = '0; bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_dc_req", {63'd0, bus.dc_req}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);

    // ALU passthrough
    send(1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 5'd5);
    chk("alu_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("alu_out_data", bus.out_data, 64'h1234);
    chk("alu_wr_en", {63'd0, bus.out_wr_en}, 64'd1);
    chk("alu_ld_or_alu", {63'd0, bus.out_ld_or_alu}, 64'd0);
    chk("alu_out_rd", {59'd0, bus.out_rd}, 64'd5);
    chk("alu_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("alu_dc_req", {63'd0, bus.dc_req}, 64'd0);
    @(negedge clk);
    chk("alu_done_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("alu_done_ready", {63'd0, bus.in_ready}, 64'd1);

    // LB sign-extended from byte lane 3
    send(1'b1, 1'b0, 3'b000, 64'h1003, 64'd0, 5'd6);
    chk("lb_dc_req", {63'd0, bus.dc_req}, 64'd1);
    chk("lb_dc_we", {63'd0, bus.dc_we}, 64'd0);
    chk("lb_dc_addr", bus.dc_addr, 64'h1000);
    chk("lb_req_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("lb_req_ready", {63'd0, bus.in_ready}, 64'd0);
    ack(64'h0000_0000_8000_0000);
    chk("lb_req_drop", {63'd0, bus.dc_req}, 64'd0);
    chk("lb_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("lb_out_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_ld_or_alu", {63'd0, bus.out_ld_or_alu}, 64'd1);
    chk("lb_wr_en", {63'd0, bus.out_wr_en}, 64'd1);
    @(negedge clk);

    // LBU zero-extended
    send(1'b1, 1'b0, 3'b100, 64'h1003, 64'd0, 5'd6);
    ack(64'h0000_0000_8000_0000);
    chk("lbu_out_data", bus.out_data, 64'h80);
    @(negedge clk);

    // SH at lane 6, with the request held across two ack-less cycles
    send(1'b0, 1'b1, 3'b001, 64'h2006, 64'hABCD, 5'd7);
    chk("sh_wstrb", {56'd0, bus.dc_wstrb}, 64'hC0);
    chk("sh_wdata", bus.dc_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_we", {63'd0, bus.dc_we}, 64'd1);
    chk("sh_addr", bus.dc_addr, 64'h2000);
    repeat (2) @(negedge clk);
    chk("sh_hold_req", {63'd0, bus.dc_req}, 64'd1);
    chk("sh_hold_wstrb", {56'd0, bus.dc_wstrb}, 64'hC0);
    chk("sh_hold_wdata", bus.dc_wdata, 64'hABCD_0000_0000_0000);
    ack(64'd0);
    chk("sh_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("sh_wr_en", {63'd0, bus.out_wr_en}, 64'd0);
    chk("sh_ld_or_alu", {63'd0, bus.out_ld_or_alu}, 64'd0);
    @(negedge clk);

    // SB at lane 5
    send(1'b0, 1'b1, 3'b000, 64'h2005, 64'hAB, 5'd7);
    chk("sb_wstrb", {56'd0, bus.dc_wstrb}, 64'h20);
    chk("sb_wdata", bus.dc_wdata, 64'h0000_AB00_0000_0000);
    ack(64'd0);
    @(negedge clk);

    // SD full doubleword
    send(1'b0, 1'b1, 3'b011, 64'h2000, 64'h1122_3344_5566_7788, 5'd7);
    chk("sd_wstrb", {56'd0, bus.dc_wstrb}, 64'hFF);
    chk("sd_wdata", bus.dc_wdata, 64'h1122_3344_5566_7788);
    ack(64'd0);
    @(negedge clk);

    // Misaligned LW: no cache access
    send(1'b1, 1'b0, 3'b010, 64'h3002, 64'd0, 5'd8);
    chk("mis_dc_req", {63'd0, bus.dc_req}, 64'd0);
    chk("mis_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("mis_flag", {63'd0, bus.out_misaligned}, 64'd1);
    chk("mis_wr_en", {63'd0, bus.out_wr_en}, 64'd0);
    chk("mis_out_data", bus.out_data, 64'h3002);
    @(negedge clk);
    chk("mis_after_req", {63'd0, bus.dc_req}, 64'd0);
    chk("mis_after_valid", {63'd0, bus.out_valid}, 64'd0);

    // Illegal load funct3 at an aligned address
    send(1'b1, 1'b0, 3'b111, 64'h3000, 64'd0, 5'd8);
    chk("ill_dc_req", {63'd0, bus.dc_req}, 64'd0);
    chk("ill_flag", {63'd0, bus.out_misaligned}, 64'd1);
    chk("ill_wr_en", {63'd0, bus.out_wr_en}, 64'd0);
    @(negedge clk);

    // LH from lane 2, sign-extended
    send(1'b1, 1'b0, 3'b001, 64'h12, 64'd0, 5'd9);
    chk("lh_dc_addr", bus.dc_addr, 64'h10);
    ack(64'h0000_0000_8001_0000);
    chk("lh_out_data", bus.out_data, 64'hFFFF_FFFF_FFFF_8001);
    chk("lh_mis_flag", {63'd0, bus.out_misaligned}, 64'd0);
    @(negedge clk);

    // LWU from lane 4, zero-extended
    send(1'b1, 1'b0, 3'b110, 64'h14, 64'd0, 5'd9);
    ack(64'hF000_0001_0000_0000);
    chk("lwu_out_data", bus.out_data, 64'h0000_0000_F000_0001);
    @(negedge clk);

    // Load and store flags both set: behaves as LW
    send(1'b1, 1'b1, 3'b010, 64'h8, 64'h55, 5'd10);
    chk("both_dc_we", {63'd0, bus.dc_we}, 64'd0);
    chk("both_dc_req", {63'd0, bus.dc_req}, 64'd1);
    ack(64'h0000_0000_FFFF_FFFF);
    chk("both_out_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("both_ld_or_alu", {63'd0, bus.out_ld_or_alu}, 64'd1);
    @(negedge clk);

    // ALU op writing x0
    send(1'b0, 1'b0, 3'b000, 64'h77, 64'd0, 5'd0);
    chk("x0_wr_en", {63'd0, bus.out_wr_en}, 64'd0);
    chk("x0_out_data", bus.out_data, 64'h77);
    @(negedge clk);

    // Backpressure after LD, with a new request presented while busy
    bus.out_ready = 1'b0;
    send(1'b1, 1'b0, 3'b011, 64'h4000, 64'd0, 5'd11);
    ack(64'h0000_0000_DEAD_BEEF);
    bus.in_valid = 1'b1;
    bus.in_is_load = 1'b0;
    bus.in_is_store = 1'b0;
    bus.in_addr = 64'h9999;
    bus.in_rd = 5'd3;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_out_data", bus.out_data, 64'h0000_0000_DEAD_BEEF);
      chk("bp_out_rd", {59'd0, bus.out_rd}, 64'd11);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    chk("bp_hold_data", bus.out_data, 64'h0000_0000_DEAD_BEEF);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("bp_rel_ready", {63'd0, bus.in_ready}, 64'd1);

    // Asynchronous reset during REQ, then a stray ack
    send(1'b1, 1'b0, 3'b011, 64'h5000, 64'd0, 5'd12);
    chk("ar_dc_req_pre", {63'd0, bus.dc_req}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_dc_req", {63'd0, bus.dc_req}, 64'd0);
    chk("ar_out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    ack(64'h1111_2222_3333_4444);
    chk("stray_ack_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("stray_ack_req", {63'd0, bus.dc_req}, 64'd0);
    chk("stray_ack_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    chk("stray_ack_valid2", {63'd0, bus.out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Load/store memory stage between the ALU and the writeback stage.
- Latches one ALU result per transaction. Non-memory ops pass straight through.
- Loads and stores drive a request/ack handshake to the data cache:
  - loads: byte-lane extraction plus sign/zero extension;
  - stores: byte strobes plus lane-shifted data.
- Results go to writeback with a valid/ready handshake and the ld_or_alu select.

Parameters:
WORDSZ, 64, datapath and address width
REGSZ, 5, destination register index width
STRBSZ, 8, byte strobes per data-cache word (WORDSZ/8)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (0 = in reset)
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept (high only in IDLE)
in_is_load  input  1  op is a load
in_is_store  input  1  op is a store
in_funct3  input  3  RISC-V funct3 of load/store
in_addr  input  WORDSZ  ALU result: effective address, or data for non-memory ops
in_store_data  input  WORDSZ  rs2 value for stores
in_rd  input  REGSZ  destination register
dc_req  output  1  data-cache request
dc_we  output  1  1 = store
dc_addr  output  WORDSZ  doubleword-aligned address ({in_addr[63:3],3'b0})
dc_wdata  output  WORDSZ  lane-shifted store data
dc_wstrb  output  STRBSZ  byte enables
dc_ack  input  1  one-cycle completion pulse; dc_rdata valid in same cycle
dc_rdata  input  WORDSZ  doubleword read data
out_valid  output  1  result valid to writeback
out_ready  input  1  writeback accepts
out_data  output  WORDSZ  load result or passed-through ALU value
out_rd  output  REGSZ  destination register
out_wr_en  output  1  regfile write enable
out_ld_or_alu  output  1  1 = load result, 0 = ALU
out_misaligned  output  1  misaligned-access flag

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; all outputs 0, except in_ready=1 once reset deasserts.
  - Any in-flight cache request is abandoned: dc_req drops immediately. After reset the cache must tolerate a stray dc_ack, which this block ignores outside REQ.
- FSM states: IDLE, REQ, OUT.
- IDLE:
  - in_ready=1. On in_valid, latch all inputs.
  - Non-memory op, or misaligned load/store -> OUT.
  - Aligned load/store -> REQ.
- REQ:
  - dc_req=1; dc_we/dc_addr/dc_wdata/dc_wstrb held stable until dc_ack.
  - On dc_ack: for a load, capture the formatted dc_rdata; then -> OUT. dc_req is 0 the cycle after ack.
- OUT:
  - out_valid=1; all out_* held stable.
  - On out_ready -> IDLE; out_valid falls next cycle.
- Throughput and latency:
  - No back-to-back acceptance: in_ready is 0 in REQ and OUT.
  - Non-memory op: out_valid asserts 1 cycle after acceptance.
  - Memory op: out_valid asserts 1 cycle after dc_ack.
- Alignment, with a = in_addr[2:0]:
  - Byte ops: always aligned.
  - Half: a[0]==0. Word: a[1:0]==0. Doubleword: a==0.
  - Misaligned: no cache access; out_misaligned=1, out_wr_en=0, out_data=in_addr.
- Load funct3 (lane = dc_rdata >> (8*a)):
  - 000 LB, 001 LH, 010 LW, 011 LD: sign-extended.
  - 100 LBU, 101 LHU, 110 LWU: zero-extended.
  - 111: illegal, handled as misaligned.
- Store funct3:
  - 000 SB: strobe 8'b1<<a.
  - 001 SH: 8'b11<<a.
  - 010 SW: 8'hF<<a.
  - 011 SD: 8'hFF.
  - dc_wdata = in_store_data << (8*a).
  - Other funct3 values: handled as misaligned.
- in_is_load and in_is_store both set: treated as a load.
- out_wr_en:
  - 1 for loads and non-memory ops.
  - 0 for stores, misaligned/illegal ops, and in_rd==0.
- out_ld_or_alu=1 only for loads.
- in_valid while in_ready=0 is ignored; the upstream stage must hold it.
- dc_ack outside REQ: ignored.

Test Plan:
- ALU passthrough: in_addr=64'h1234, rd=5, no mem -> next cycle out_valid=1, out_data=64'h1234, out_wr_en=1, out_ld_or_alu=0.
- LB at addr 0x1003, dc_rdata=64'h0000_0000_8000_0000 -> dc_addr=0x1000; out_data=64'hFFFF_FFFF_FFFF_FF80.
- LBU at the same address -> out_data=64'h80.
- SH at addr 0x2006, data=64'hABCD -> dc_wstrb=8'hC0, dc_wdata=64'hABCD_0000_0000_0000, dc_we=1, out_wr_en=0.
- LW at addr 0x3002 -> no dc_req ever; out_misaligned=1, out_wr_en=0.
- Backpressure: out_ready=0 for 3 cycles after an LD returns 64'hDEAD_BEEF -> out_* stable, in_ready=0; on out_ready=1, IDLE next cycle.
- Reset low mid-REQ with dc_req=1 -> dc_req=0 immediately, out_valid=0; a dc_ack arriving 1 cycle after reset release produces no out_valid.
